// File: rtl/seq_pkg.sv
// Shared definitions for the 3-bit cyclic sequence (6,3,5,7,2,1) and its checker.
package seq_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } seq_state_t;

    localparam logic [2:0] SEQ_FIRST = 3'd6;
    localparam logic [2:0] SEQ_LAST  = 3'd1;

    // Returns {valid, next}; 0 and 4 are not part of the cycle and come back invalid.
    function automatic logic [3:0] seq_succ(input logic [2:0] v);
        logic [3:0] r;
        case (v)
            3'd6:    r = {1'b1, 3'd3};
            3'd3:    r = {1'b1, 3'd5};
            3'd5:    r = {1'b1, 3'd7};
            3'd7:    r = {1'b1, 3'd2};
            3'd2:    r = {1'b1, 3'd1};
            3'd1:    r = {1'b1, 3'd6};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_stream_checker_if.sv
// Sample and status bundle between a sequence source and the stream checker.
interface seq_stream_checker_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       y;
    logic             y_valid;
    logic             err_clr;
    logic             locked;
    logic             err;
    logic             period_done;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output y, y_valid, err_clr,
        input  locked, err, period_done, err_cnt
    );

    modport slave (
        input  y, y_valid, err_clr,
        output locked, err, period_done, err_cnt
    );
endinterface

// File: rtl/seq_stream_checker.sv
// Receive-side monitor: acquires phase of the 6,3,5,7,2,1 cycle, locks after a
// run of correct predictions, then flags and counts every deviation.
module seq_stream_checker
    import seq_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int LOCK_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_stream_checker_if.slave  bus
);

    localparam logic [7:0]       THRESH  = 8'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t       state;
    logic [2:0]       exp_q;
    logic [7:0]       match_cnt;
    logic             locked_q;
    logic             err_q;
    logic             period_done_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [3:0]       succ_w;
    logic             succ_valid;
    logic [2:0]       succ_next;
    logic             hit;
    logic             err_hit;
    logic [7:0]       match_nxt;

    assign succ_w     = seq_succ(bus.y);
    assign succ_valid = succ_w[3];
    assign succ_next  = succ_w[2:0];
    assign hit        = (bus.y == exp_q);
    assign err_hit    = bus.y_valid && (state == LOCKED) && !hit;
    assign match_nxt  = match_cnt + 8'd1;

    // Phase tracking FSM with registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            exp_q         <= 3'd0;
            match_cnt     <= 8'd0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            err_q         <= 1'b0;
            period_done_q <= 1'b0;
            if (bus.y_valid) begin
                if (state == HUNT) begin
                    if (succ_valid) begin
                        exp_q     <= succ_next;
                        match_cnt <= 8'd0;
                        state     <= ACQUIRE;
                    end
                end else if (hit) begin
                    // exp_q is always a member here, so a hit implies a valid successor.
                    exp_q <= succ_next;
                    if (state == ACQUIRE) begin
                        match_cnt <= match_nxt;
                        if (match_nxt == THRESH) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        period_done_q <= (bus.y == SEQ_LAST);
                    end
                end else begin
                    err_q    <= (state == LOCKED);
                    locked_q <= 1'b0;
                    if (succ_valid) begin
                        exp_q     <= succ_next;
                        match_cnt <= 8'd0;
                        state     <= ACQUIRE;
                    end else begin
                        state <= HUNT;
                    end
                end
            end
        end
    end

    // Saturating error counter; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            err_cnt_q <= '0;
        end else if (err_hit && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.err         = err_q;
    assign bus.period_done = period_done_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule
